// File: rtl/led_pkg.sv
// Shared encodings and parameter helpers for the LED pattern sequencer.
package led_pkg;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PLAY = 1'b1
   } led_state_t;

   localparam int DEF_CLK_FREQ = 16_000_000;
   localparam int DEF_STEP_HZ  = 8;

   // Clock cycles per pattern step.
   function automatic int calc_div(input int clk_freq, input int step_hz);
      return clk_freq / step_hz;
   endfunction

   // A step must span at least two cycles so the terminal count differs from the load value.
   function automatic bit div_ok(input int div);
      return div >= 2;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Step-rate prescaler: counts 0..DIV-1 and flags the terminal count.
module tick_gen #(
   parameter int DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic CLR,
   output logic TICK
);

   localparam int               CNT_W    = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   assign TICK = (cnt_q == CNT_LAST);

   // Wrap counter; CLR restarts a step so it lasts exactly DIV cycles.
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         cnt_q <= '0;
      end else if (TICK) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_seq.sv
// Plays a handshaked on/off pattern on the LED at a fixed step rate, PWM-dimmed.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | no pattern; PAT_READY high, LED dark
//  S_PLAY | stepping through pat_q MSB first, one step per prescaler tick
module led_pattern_seq
   import led_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int STEP_HZ  = DEF_STEP_HZ,
   parameter int PAT_W    = 16,
   parameter int PWM_W    = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [PAT_W-1:0] PAT_DATA,
   input  logic             PAT_VALID,
   output logic             PAT_READY,
   input  logic             REPEAT,
   input  logic [PWM_W-1:0] BRIGHT,
   output logic             BUSY,
   output logic             LED
);

   localparam int               DIV      = calc_div(CLK_FREQ, STEP_HZ);
   localparam int               IDX_W    = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

   if (!div_ok(DIV)) begin : g_div_check
      $error("led_pattern_seq: CLK_FREQ/STEP_HZ must be at least 2");
   end

   led_state_t       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PWM_W-1:0] pwm_cnt_q;
   logic [IDX_W-1:0] bit_sel;
   logic             tick;
   logic             tick_clr;
   logic             last_step;
   logic             xfer;
   logic             pwm_on;
   logic             led_d;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .CLK  (CLK),
      .RST  (RST),
      .CLR  (tick_clr),
      .TICK (tick)
   );

   assign last_step = (idx_q == IDX_LAST);
   // A new word is taken when idle, or on the very tick that finishes the last step,
   // so a replacement pattern follows with no gap cycle.
   assign PAT_READY = (state_q == S_IDLE) | ((state_q == S_PLAY) & tick & last_step);
   assign xfer      = PAT_VALID & PAT_READY;
   assign BUSY      = (state_q == S_PLAY);

   // Next-state, step index and pattern latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      pat_d    = pat_q;
      tick_clr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               state_d  = S_PLAY;
               pat_d    = PAT_DATA;
               idx_d    = '0;
               tick_clr = 1'b1;
            end
         end
         S_PLAY: begin
            if (tick) begin
               if (!last_step) begin
                  idx_d = idx_q + IDX_W'(1);
               end else if (xfer) begin
                  pat_d = PAT_DATA;
                  idx_d = '0;
               end else if (REPEAT) begin
                  idx_d = '0;
               end else begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State, index and pattern registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         pat_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pat_q   <= pat_d;
      end
   end

   assign bit_sel = IDX_LAST - idx_q;
   // All-ones brightness is forced fully on; otherwise the compare gives BRIGHT/2^PWM_W duty.
   assign pwm_on  = (BRIGHT == {PWM_W{1'b1}}) | (pwm_cnt_q < BRIGHT);
   assign led_d   = (state_q == S_PLAY) & pat_q[bit_sel] & pwm_on;

   // Free-running PWM phase and registered LED drive.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pwm_cnt_q <= '0;
         LED       <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
         LED       <= led_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq (DIV=4, PAT_W=16, PWM_W=4).
module tb_led_pattern_seq;

   localparam int PAT_W = 16;
   localparam int PWM_W = 4;
   localparam int STEPS = 16;
   localparam int DIVB  = 4;
   localparam int PLAY  = STEPS * DIVB;

   logic             CLK;
   logic             RST;
   logic [PAT_W-1:0] PAT_DATA;
   logic             PAT_VALID;
   logic             PAT_READY;
   logic             REPEAT;
   logic [PWM_W-1:0] BRIGHT;
   logic             BUSY;
   logic             LED;

   led_pattern_seq #(
      .CLK_FREQ (16),
      .STEP_HZ  (4),
      .PAT_W    (PAT_W),
      .PWM_W    (PWM_W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .PAT_DATA  (PAT_DATA),
      .PAT_VALID (PAT_VALID),
      .PAT_READY (PAT_READY),
      .REPEAT    (REPEAT),
      .BRIGHT    (BRIGHT),
      .BUSY      (BUSY),
      .LED       (LED)
   );

   typedef struct {
      logic  led;
      logic  busy;
      logic  ready;
      string tag;
   } exp_t;

   typedef struct {
      logic [PAT_W-1:0] pat;
      logic [PWM_W-1:0] bright;
      int               loops;
      string            name;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   n_vec = 0;
   int   n_err = 0;
   int   edges = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Edges since the last reset edge: this is the PWM phase after each edge.
   always @(posedge CLK) begin
      if (RST) edges <= 0;
      else     edges <= edges + 1;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic led, input logic busy, input logic ready, input string tag);
      exp_t e;
      e.led = led; e.busy = busy; e.ready = ready; e.tag = tag;
      sb.push_back(e);
   endtask

   // Expectations for a load on the next edge (k=0 is the sample after the load edge).
   // Play 0 uses pa, later plays use pb; only the first n samples are queued.
   task automatic push_play(input logic [PAT_W-1:0] pa, input logic [PAT_W-1:0] pb,
                            input int loops, input logic [PWM_W-1:0] bright,
                            input int n, input string name);
      int total, e0, p, step, ph;
      logic [PAT_W-1:0] pat;
      logic led, on;
      total = PLAY * loops;
      e0    = edges;
      for (int k = 0; k < n; k++) begin
         led = 1'b0;
         if (k >= 1 && k <= total) begin
            p    = (k - 1) / PLAY;
            step = ((k - 1) % PLAY) / DIVB;
            pat  = (p == 0) ? pa : pb;
            ph   = (e0 + k) % 16;
            on   = (bright == 4'hF) || (ph < int'(bright));
            led  = pat[PAT_W-1-step] & on;
         end
         push_exp(led, k < total, (k >= total) || (k % PLAY == PLAY - 1),
                  $sformatf("%s k=%0d", name, k));
      end
   endtask

   // Advance to the next sample point and compare against the scoreboard head.
   task automatic cyc();
      exp_t e;
      @(negedge CLK);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec++;
         if (LED !== e.led || BUSY !== e.busy || PAT_READY !== e.ready) begin
            n_err++;
            $display("FAIL %s: led/busy/ready got %b/%b/%b expected %b/%b/%b",
                     e.tag, LED, BUSY, PAT_READY, e.led, e.busy, e.ready);
         end
      end
   endtask

   task automatic play_vec(input vec_t v);
      int n;
      n = PLAY * v.loops + 2;
      push_play(v.pat, v.pat, v.loops, v.bright, n, v.name);
      PAT_DATA  = v.pat;
      PAT_VALID = 1'b1;
      REPEAT    = (v.loops > 1);
      BRIGHT    = v.bright;
      for (int j = 0; j < n; j++) begin
         cyc();
         PAT_VALID = 1'b0;
         PAT_DATA  = 16'($urandom);
         REPEAT    = (j < PLAY * (v.loops - 1));
      end
   endtask

   // Offer pb during play of pa; it may only be taken on the tick ending step 15.
   task automatic replace_seq(input logic [PAT_W-1:0] pa, input logic [PAT_W-1:0] pb,
                              input bit scramble, input string name);
      int n;
      n = 2 * PLAY + 2;
      push_play(pa, pb, 2, 4'hF, n, name);
      PAT_DATA  = pa;
      PAT_VALID = 1'b1;
      REPEAT    = 1'b1;
      BRIGHT    = 4'hF;
      for (int j = 0; j < n; j++) begin
         cyc();
         if (j < PLAY) begin
            PAT_VALID = 1'b1;
            PAT_DATA  = (scramble && j < PLAY - 1) ? 16'($urandom) : pb;
            REPEAT    = 1'b1;
         end else begin
            PAT_VALID = 1'b0;
            PAT_DATA  = 16'($urandom);
            REPEAT    = 1'b0;
         end
      end
   endtask

   task automatic reset_mid();
      push_play(16'hFFFF, 16'hFFFF, 2, 4'hF, 10, "pre_reset");
      PAT_DATA  = 16'hFFFF;
      PAT_VALID = 1'b1;
      REPEAT    = 1'b1;
      BRIGHT    = 4'hF;
      for (int j = 0; j < 10; j++) begin
         cyc();
         PAT_VALID = 1'b0;
      end
      RST = 1'b1;
      for (int j = 0; j < 3; j++) push_exp(1'b0, 1'b0, 1'b1, $sformatf("in_reset %0d", j));
      repeat (3) cyc();
      RST    = 1'b0;
      REPEAT = 1'b0;
      push_exp(1'b0, 1'b0, 1'b1, "after_reset");
      cyc();
   endtask

   initial begin
      vecs[0] = '{pat: 16'hA000, bright: 4'hF, loops: 1, name: "oneshot_A000"};
      vecs[1] = '{pat: 16'h8001, bright: 4'hF, loops: 2, name: "loop_8001"};
      vecs[2] = '{pat: 16'hFFFF, bright: 4'h4, loops: 2, name: "pwm_b4"};
      vecs[3] = '{pat: 16'hFFFF, bright: 4'h0, loops: 1, name: "pwm_b0"};
      vecs[4] = '{pat: 16'hFFFF, bright: 4'hF, loops: 2, name: "pwm_b15"};
      vecs[5] = '{pat: 16'h5A5A, bright: 4'h9, loops: 1, name: "mixed_5A5A"};
      vecs[6] = '{pat: 16'h0001, bright: 4'hE, loops: 1, name: "last_bit"};

      RST       = 1'b1;
      PAT_DATA  = '0;
      PAT_VALID = 1'b0;
      REPEAT    = 1'b0;
      BRIGHT    = '0;
      repeat (2) @(negedge CLK);
      push_exp(1'b0, 1'b0, 1'b1, "reset_state");
      cyc();
      RST = 1'b0;
      push_exp(1'b0, 1'b0, 1'b1, "first_after_reset");
      cyc();
      repeat (3) cyc();

      foreach (vecs[i]) play_vec(vecs[i]);

      replace_seq(16'h8000, 16'hFFFF, 1'b0, "replace");
      replace_seq(16'h0000, 16'hC3C3, 1'b1, "stall");
      reset_mid();
      play_vec(vecs[0]);

      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
